// File: rtl/csa_mult_pipe_pkg.sv
// Shared definitions for the carry-save multiplier.
// Contents: mode encodings and the elaboration-time helpers that size the 3:2 reduction tree.
package mult_pkg;

  localparam logic MODE_UNSIGNED = 1'b0;
  localparam logic MODE_SIGNED   = 1'b1;

  // Rows left after `level` layers of 3:2 reduction. Each layer turns every full group of
  // three rows into two and passes the leftover rows straight through.
  function automatic int unsigned rows_at_level(input int unsigned rows, input int unsigned level);
    int unsigned n;
    n = rows;
    for (int unsigned i = 0; i < level; i++) begin
      if (n > 2) n = n - n / 3;
    end
    return n;
  endfunction

  // Number of 3:2 layers needed to bring `rows` down to two vectors.
  function automatic int unsigned tree_levels(input int unsigned rows);
    int unsigned n;
    int unsigned lv;
    n  = rows;
    lv = 0;
    while (n > 2) begin
      n  = n - n / 3;
      lv = lv + 1;
    end
    return lv;
  endfunction

endpackage

// File: rtl/csa_mult_pipe_csa_3to2.sv
// Bitwise 3:2 counter (row of full adders).
// Ports:
//   a_i, b_i, c_i : three W-bit addends
//   sum_o         : bitwise sum
//   carry_o       : bitwise majority, NOT shifted; the caller applies the x2 weight
module csa_3to2 #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] c_i,
  output logic [W-1:0] sum_o,
  output logic [W-1:0] carry_o
);

  assign sum_o   = a_i ^ b_i ^ c_i;
  assign carry_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/csa_mult_pipe.sv
// Three-stage pipelined carry-save array multiplier with valid/ready streams.
//   S0: operands and effective mode
//   S1: sum/carry vectors from the 3:2 reduction tree
//   S2: final carry-lookahead sum and overflow flag (drives the outputs)
// Ports:
//   clk, rst_n             : clock, synchronous active-low reset
//   in_valid/in_ready      : operand handshake; in_x, in_y, in_signed are the beat
//   out_valid/out_ready    : result handshake; out_product (2*WIDTH), out_of
module csa_mult_pipe
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          SIGNED_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_x,
  input  logic [WIDTH-1:0]   in_y,
  input  logic               in_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_product,
  output logic               out_of
);

  localparam int unsigned ProdW  = 2 * WIDTH;
  // One row per multiplier bit plus the +1 row that completes the negated top row.
  localparam int unsigned NRows  = WIDTH + 1;
  localparam int unsigned Levels = tree_levels(NRows);

  // ---------------------------------------------------------------------------
  // Handshake: a stage loads when it is empty or its content moves on this edge.
  // ---------------------------------------------------------------------------
  logic s0_valid_q, s1_valid_q;
  logic s0_load, s1_load, s2_load;

  assign s2_load  = ~out_valid | out_ready;
  assign s1_load  = ~s1_valid_q | s2_load;
  assign s0_load  = ~s0_valid_q | s1_load;
  assign in_ready = s0_load;

  // ---------------------------------------------------------------------------
  // S0: operand registers
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] s0_x_q, s0_y_q;
  logic             s0_mode_q;
  logic             in_mode;

  assign in_mode = SIGNED_EN ? in_signed : MODE_UNSIGNED;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s0_valid_q <= 1'b0;
      s0_x_q     <= '0;
      s0_y_q     <= '0;
      s0_mode_q  <= MODE_UNSIGNED;
    end else if (s0_load) begin
      s0_valid_q <= in_valid;
      if (in_valid) begin
        s0_x_q    <= in_x;
        s0_y_q    <= in_y;
        s0_mode_q <= in_mode;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Partial products. In signed mode the multiplier's sign bit carries weight
  // -2^(WIDTH-1), so its row is subtracted as ~row + 1 (the +1 is the last row).
  // ---------------------------------------------------------------------------
  logic [ProdW-1:0]            x_ext;
  logic [NRows-1:0][ProdW-1:0] pp;

  always_comb begin
    x_ext = {{WIDTH{s0_mode_q & s0_x_q[WIDTH-1]}}, s0_x_q};
    pp    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pp[i] = s0_y_q[i] ? (x_ext << i) : '0;
    end
    if (s0_mode_q == MODE_SIGNED && s0_y_q[WIDTH-1]) begin
      pp[WIDTH-1] = ~pp[WIDTH-1];
      pp[WIDTH]   = {{(ProdW - 1){1'b0}}, 1'b1};
    end
  end

  // ---------------------------------------------------------------------------
  // 3:2 reduction tree. Level lv holds rows_at_level(NRows, lv) vectors; each
  // level groups the previous level's rows in threes and passes leftovers on.
  // ---------------------------------------------------------------------------
  for (genvar lv = 0; lv <= Levels; lv++) begin : g_lvl
    localparam int unsigned NCur = rows_at_level(NRows, lv);
    logic [NCur-1:0][ProdW-1:0] rows;

    if (lv == 0) begin : g_leaf
      assign rows = pp;
    end else begin : g_node
      localparam int unsigned NPrev = rows_at_level(NRows, lv - 1);
      localparam int unsigned NGrp  = NPrev / 3;

      for (genvar g = 0; g < NGrp; g++) begin : g_csa
        logic [ProdW-1:0] carry;
        logic             unused_carry_msb;

        csa_3to2 #(
          .W (ProdW)
        ) u_csa (
          .a_i     (g_lvl[lv-1].rows[3*g]),
          .b_i     (g_lvl[lv-1].rows[3*g+1]),
          .c_i     (g_lvl[lv-1].rows[3*g+2]),
          .sum_o   (rows[2*g]),
          .carry_o (carry)
        );

        // Carry weight is x2; the bit shifted out is beyond the product width.
        assign rows[2*g+1]      = {carry[ProdW-2:0], 1'b0};
        assign unused_carry_msb = carry[ProdW-1];
      end

      for (genvar r = 3 * NGrp; r < NPrev; r++) begin : g_pass
        assign rows[r-NGrp] = g_lvl[lv-1].rows[r];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // S1: carry-save pair
  // ---------------------------------------------------------------------------
  logic [ProdW-1:0] s1_sum_q, s1_carry_q;
  logic             s1_mode_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_sum_q   <= '0;
      s1_carry_q <= '0;
      s1_mode_q  <= MODE_UNSIGNED;
    end else if (s1_load) begin
      s1_valid_q <= s0_valid_q;
      if (s0_valid_q) begin
        s1_sum_q   <= g_lvl[Levels].rows[0];
        s1_carry_q <= g_lvl[Levels].rows[1];
        s1_mode_q  <= s0_mode_q;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Final add: Kogge-Stone prefix over generate/propagate, cin = 0. After the
  // prefix, add_g[i] is the carry out of bit i.
  // ---------------------------------------------------------------------------
  logic [ProdW-1:0] add_hp, add_g, add_p, prod_d;
  logic             of_d;

  always_comb begin
    add_hp = s1_sum_q ^ s1_carry_q;
    add_g  = s1_sum_q & s1_carry_q;
    add_p  = add_hp;
    for (int d = 1; d < int'(ProdW); d = d * 2) begin
      add_g = add_g | (add_p & (add_g << d));
      add_p = add_p & (add_p << d);
    end
    prod_d = add_hp ^ {add_g[ProdW-2:0], 1'b0};

    if (s1_mode_q == MODE_SIGNED) begin
      // Fits in WIDTH signed bits only if the upper half matches the sign bit.
      of_d = ~((&prod_d[ProdW-1:WIDTH-1]) | ~(|prod_d[ProdW-1:WIDTH-1]));
    end else begin
      of_d = |prod_d[ProdW-1:WIDTH];
    end
  end

  // ---------------------------------------------------------------------------
  // S2: output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_product <= '0;
      out_of      <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid_q;
      if (s1_valid_q) begin
        out_product <= prod_d;
        out_of      <= of_d;
      end
    end
  end

endmodule

// File: tb/tb_csa_mult_pipe.sv
// Self-checking bench: four multipliers (8-bit signed-capable, 8-bit unsigned-only,
// 4-bit, 16-bit) share one handshake and see the same operands (truncated per width).
module tb_csa_mult_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid, out_ready, in_signed;
  logic [15:0] in_x, in_y;

  logic        rdy8, rdy8u, rdy4, rdy16;
  logic        ov8, ov8u, ov4, ov16;
  logic        of8, of8u, of4, of16;
  logic [15:0] p8, p8u;
  logic [7:0]  p4;
  logic [31:0] p16;

  csa_mult_pipe #(.WIDTH(8), .SIGNED_EN(1'b1)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy8),
    .in_x(in_x[7:0]), .in_y(in_y[7:0]), .in_signed(in_signed),
    .out_valid(ov8), .out_ready(out_ready), .out_product(p8), .out_of(of8)
  );
  csa_mult_pipe #(.WIDTH(8), .SIGNED_EN(1'b0)) u_dut8u (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy8u),
    .in_x(in_x[7:0]), .in_y(in_y[7:0]), .in_signed(in_signed),
    .out_valid(ov8u), .out_ready(out_ready), .out_product(p8u), .out_of(of8u)
  );
  csa_mult_pipe #(.WIDTH(4), .SIGNED_EN(1'b1)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy4),
    .in_x(in_x[3:0]), .in_y(in_y[3:0]), .in_signed(in_signed),
    .out_valid(ov4), .out_ready(out_ready), .out_product(p4), .out_of(of4)
  );
  csa_mult_pipe #(.WIDTH(16), .SIGNED_EN(1'b1)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy16),
    .in_x(in_x), .in_y(in_y), .in_signed(in_signed),
    .out_valid(ov16), .out_ready(out_ready), .out_product(p16), .out_of(of16)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] p;
    logic        o;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [7:0]  x;
    logic [7:0]  y;
    bit          sgn;
    logic [15:0] ps;  // expected from the signed-capable 8-bit block
    logic        os;
    logic [15:0] pu;  // expected from the unsigned-only 8-bit block
    logic        ou;
  } vec_t;

  // Arithmetic reference: plain integer multiply, range test for overflow.
  function automatic exp_t model(input int w, input logic [15:0] x, input logic [15:0] y,
                                 input bit sgn, input int cyc);
    longint a, b, p, m;
    exp_t   e;
    m = (64'sd1 <<< w) - 1;
    a = longint'(x) & m;
    b = longint'(y) & m;
    if (sgn && a[w-1]) a = a - (64'sd1 <<< w);
    if (sgn && b[w-1]) b = b - (64'sd1 <<< w);
    p = a * b;
    e.p = 32'(p & ((64'sd1 <<< (2 * w)) - 1));
    if (sgn) e.o = (p < -(64'sd1 <<< (w - 1))) || (p >= (64'sd1 <<< (w - 1)));
    else     e.o = (p >= (64'sd1 <<< w));
    e.cyc = cyc;
    return e;
  endfunction

  exp_t q8[$], q8u[$], q4[$], q16[$];
  int   out_cyc[$];
  int   cyc = 0;
  int   acc8 = 0;
  bit   lat_chk = 1'b0;
  bit   tab_mode = 1'b0;
  vec_t cur;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: record accepted beats, compare delivered beats.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (in_valid && rdy8) begin
        if (tab_mode) begin
          e.p = {16'h0, cur.ps}; e.o = cur.os; e.cyc = cyc; q8.push_back(e);
          e.p = {16'h0, cur.pu}; e.o = cur.ou; q8u.push_back(e);
        end else begin
          q8.push_back(model(8, in_x, in_y, in_signed, cyc));
          q8u.push_back(model(8, in_x, in_y, 1'b0, cyc));
        end
        acc8++;
      end
      if (in_valid && rdy4)  q4.push_back(model(4, in_x, in_y, in_signed, cyc));
      if (in_valid && rdy16) q16.push_back(model(16, in_x, in_y, in_signed, cyc));

      if (ov8 && out_ready) begin
        check("dut8 beat expected", q8.size() != 0, 1'b1);
        if (q8.size() != 0) begin
          e = q8.pop_front();
          check("dut8 product", p8, e.p);
          check("dut8 of", of8, e.o);
          if (lat_chk) check("dut8 latency", cyc - e.cyc, 3);
          out_cyc.push_back(cyc);
        end
      end
      if (ov8u && out_ready) begin
        check("dut8u beat expected", q8u.size() != 0, 1'b1);
        if (q8u.size() != 0) begin
          e = q8u.pop_front();
          check("dut8u product", p8u, e.p);
          check("dut8u of", of8u, e.o);
        end
      end
      if (ov4 && out_ready) begin
        check("dut4 beat expected", q4.size() != 0, 1'b1);
        if (q4.size() != 0) begin
          e = q4.pop_front();
          check("dut4 product", p4, e.p);
          check("dut4 of", of4, e.o);
        end
      end
      if (ov16 && out_ready) begin
        check("dut16 beat expected", q16.size() != 0, 1'b1);
        if (q16.size() != 0) begin
          e = q16.pop_front();
          check("dut16 product", p16, e.p);
          check("dut16 of", of16, e.o);
          if (lat_chk) check("dut16 latency", cyc - e.cyc, 3);
        end
      end
    end
  end

  task automatic send(input logic [15:0] x, input logic [15:0] y, input bit sgn);
    int n;
    n = 0;
    in_x = x; in_y = y; in_signed = sgn; in_valid = 1'b1;
    @(negedge clk);
    while (!rdy8 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("send accepted", rdy8, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    int left;
    n = 0;
    @(negedge clk);
    left = q8.size() + q8u.size() + q4.size() + q16.size();
    while (left != 0 && n < 30) begin
      @(negedge clk);
      n++;
      left = q8.size() + q8u.size() + q4.size() + q16.size();
    end
    check("drain empty", left, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_consecutive(input string name, input int n);
    check({name, " count"}, out_cyc.size(), n);
    for (int i = 1; i < out_cyc.size(); i++) check({name, " spacing"}, out_cyc[i] - out_cyc[i-1], 1);
  endtask

  vec_t        tab[11];
  logic [15:0] cx[6] = '{16'h0000, 16'h0000, 16'h0008, 16'h0080, 16'h8000, 16'h8000};
  logic [15:0] cy[6] = '{16'hFFFF, 16'hFFFF, 16'h0008, 16'h0080, 16'h8000, 16'h8000};
  bit          cs[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    //          x      y     sgn   signed-capable    unsigned-only
    tab[0]  = '{8'hFF, 8'hFF, 1'b0, 16'hFE01, 1'b1, 16'hFE01, 1'b1};
    tab[1]  = '{8'h0D, 8'h0B, 1'b0, 16'h008F, 1'b0, 16'h008F, 1'b0};
    tab[2]  = '{8'h80, 8'h80, 1'b1, 16'h4000, 1'b1, 16'h4000, 1'b1};
    tab[3]  = '{8'hFD, 8'h05, 1'b1, 16'hFFF1, 1'b0, 16'h04F1, 1'b1};
    tab[4]  = '{8'h7F, 8'h7F, 1'b1, 16'h3F01, 1'b1, 16'h3F01, 1'b1};
    tab[5]  = '{8'hFF, 8'hFF, 1'b1, 16'h0001, 1'b0, 16'hFE01, 1'b1};
    tab[6]  = '{8'h80, 8'h01, 1'b1, 16'hFF80, 1'b0, 16'h0080, 1'b0};
    tab[7]  = '{8'h00, 8'hFF, 1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0};
    tab[8]  = '{8'h10, 8'h10, 1'b0, 16'h0100, 1'b1, 16'h0100, 1'b1};
    tab[9]  = '{8'h05, 8'hFD, 1'b1, 16'hFFF1, 1'b0, 16'h04F1, 1'b1};
    tab[10] = '{8'h80, 8'h7F, 1'b1, 16'hC080, 1'b1, 16'h3F80, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_x = '0; in_y = '0; in_signed = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    check("reset out_valid", ov8, 1'b0);
    check("reset product", p8, 16'h0);
    check("reset of", of8, 1'b0);
    check("reset in_ready", rdy8, 1'b1);
    check("reset out_valid w16", ov16, 1'b0);
    @(posedge clk);
    #1;

    // Directed vectors, one at a time, no stalls
    lat_chk  = 1'b1;
    tab_mode = 1'b1;
    for (int i = 0; i < 11; i++) begin
      cur = tab[i];
      send({8'h0, tab[i].x}, {8'h0, tab[i].y}, tab[i].sgn);
      in_valid = 1'b0;
      drain();
    end
    tab_mode = 1'b0;

    // Backpressure: three beats fill the pipe, the fourth is refused
    lat_chk = 1'b0;
    out_ready = 1'b0;
    acc8 = 0;
    out_cyc.delete();
    send(16'd1, 16'd1, 1'b0);
    send(16'd2, 16'd2, 1'b0);
    send(16'd3, 16'd3, 1'b0);
    in_x = 16'd4; in_y = 16'd4; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("bp in_ready low", rdy8, 1'b0);
      check("bp out_valid held", ov8, 1'b1);
      check("bp product held", p8, 16'h0001);
      check("bp of held", of8, 1'b0);
    end
    check("bp accepted count", acc8, 3);
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(16'd4, 16'd4, 1'b0);
    in_valid = 1'b0;
    drain();
    check_consecutive("bp drain", 4);

    // Throughput: corners then random, back to back
    lat_chk = 1'b1;
    out_cyc.delete();
    for (int i = 0; i < 6; i++) send(cx[i], cy[i], cs[i]);
    for (int i = 0; i < 20; i++) send(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
    in_valid = 1'b0;
    drain();
    check_consecutive("stream", 26);

    // Reset with a full pipe
    lat_chk = 1'b0;
    out_ready = 1'b0;
    send(16'd5, 16'd6, 1'b0);
    send(16'd7, 16'd8, 1'b1);
    send(16'd9, 16'd10, 1'b0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    q8.delete(); q8u.delete(); q4.delete(); q16.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("mid-reset out_valid", ov8, 1'b0);
    check("mid-reset out_valid w4", ov4, 1'b0);
    check("mid-reset in_ready", rdy8, 1'b1);
    check("mid-reset product", p8, 16'h0);
    out_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("no stale beat", ov8 | ov8u | ov4 | ov16, 1'b0);
    end
    @(posedge clk);
    #1;
    send(16'hFFFA, 16'h0007, 1'b1);
    in_valid = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
